// File: rtl/demux_3bits_bank_if.sv
// Bus bundle for the registered 1-to-8 demux bank: write-side controls in, slot state out.
interface demux_3bits_bank_if;
    // Controls toward the bank
    logic [2:0]  ctrl;
    logic [31:0] in;
    logic        wr_en;
    logic        auto_mode;
    logic [7:0]  consume;
    logic        clr_ovw;
    // Registered slot state from the bank
    logic [31:0] o0, o1, o2, o3, o4, o5, o6, o7;
    logic [7:0]  valid;
    logic [3:0]  count;
    logic        full;
    logic [2:0]  ptr;
    logic        ovw;

    // Handshake: there is no valid/ready pair. wr_en is a fire-and-forget strobe,
    // one write accepted on every rising edge where it is high; the bank never
    // stalls, and writing into a valid, unconsumed slot is reported through ovw.
    modport master (
        output ctrl, in, wr_en, auto_mode, consume, clr_ovw,
        input  o0, o1, o2, o3, o4, o5, o6, o7, valid, count, full, ptr, ovw
    );
    modport slave (
        input  ctrl, in, wr_en, auto_mode, consume, clr_ovw,
        output o0, o1, o2, o3, o4, o5, o6, o7, valid, count, full, ptr, ovw
    );
endinterface

// File: rtl/demux_3bits_bank.sv
// Registered 1-to-8 demultiplexer bank: steers a 32-bit word into one of eight
// holding slots (manual select or wrap-around pointer), tracking per-slot valid
// flags, occupancy count and a sticky overwrite flag.
module demux_3bits_bank (
    input  logic                     clk,
    input  logic                     reset,
    demux_3bits_bank_if.slave        bus
);
    logic [31:0] data_q [8];
    logic [7:0]  valid_q, valid_d;
    logic [3:0]  count_q, count_d;
    logic [2:0]  ptr_q, ptr_d;
    logic        ovw_q, ovw_d;
    logic [2:0]  tgt;
    logic [7:0]  wr_onehot;
    logic        new_ovw;

    // Next-state: target decode, valid update (write beats consume), ovw and pointer
    always_comb begin
        tgt       = bus.auto_mode ? ptr_q : bus.ctrl;
        wr_onehot = bus.wr_en ? (8'd1 << tgt) : 8'd0;
        valid_d   = (valid_q & ~bus.consume) | wr_onehot;
        new_ovw   = bus.wr_en & valid_q[tgt] & ~bus.consume[tgt];
        ovw_d     = (ovw_q & ~bus.clr_ovw) | new_ovw;
        ptr_d     = (bus.wr_en && bus.auto_mode) ? ptr_q + 3'd1 : ptr_q;
        count_d   = 4'd0;
        for (int i = 0; i < 8; i++) begin
            count_d = count_d + {3'b000, valid_d[i]};
        end
    end

    // Control state registers; reset overrides any same-cycle write or consume
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 8'd0;
            count_q <= 4'd0;
            ptr_q   <= 3'd0;
            ovw_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            ptr_q   <= ptr_d;
            ovw_q   <= ovw_d;
        end
    end

    // Slot data: only the targeted slot loads; consume never touches data
    always_ff @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (reset) begin
                data_q[i] <= 32'd0;
            end else if (wr_onehot[i]) begin
                data_q[i] <= bus.in;
            end
        end
    end

    assign bus.o0    = data_q[0];
    assign bus.o1    = data_q[1];
    assign bus.o2    = data_q[2];
    assign bus.o3    = data_q[3];
    assign bus.o4    = data_q[4];
    assign bus.o5    = data_q[5];
    assign bus.o6    = data_q[6];
    assign bus.o7    = data_q[7];
    assign bus.valid = valid_q;
    assign bus.count = count_q;
    assign bus.full  = (valid_q == 8'hFF);
    assign bus.ptr   = ptr_q;
    assign bus.ovw   = ovw_q;
endmodule

// File: tb/tb_demux_3bits_bank.sv
// Directed bench for demux_3bits_bank: behavioural slot model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_demux_3bits_bank;
    logic clk;
    logic reset;
    demux_3bits_bank_if bus ();

    demux_3bits_bank dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    // ---------------- behavioural model ----------------
    logic [31:0] m_data [8];
    bit          m_valid [8];
    int          m_ptr;
    bit          m_ovw;

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < 8; i++) n += m_valid[i];
        return n;
    endfunction

    function automatic logic [7:0] m_valid_vec();
        logic [7:0] v = 8'd0;
        for (int i = 0; i < 8; i++) v[i] = m_valid[i];
        return v;
    endfunction

    // Apply the inputs present at this edge to the model
    task automatic model_step();
        int  t;
        bit  hit;
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                m_data[i]  = 32'd0;
                m_valid[i] = 1'b0;
            end
            m_ptr = 0;
            m_ovw = 1'b0;
        end else begin
            t   = bus.auto_mode ? m_ptr : int'(bus.ctrl);
            hit = bus.wr_en && m_valid[t] && !bus.consume[t];
            for (int i = 0; i < 8; i++) begin
                if (bus.consume[i]) m_valid[i] = 1'b0;
            end
            if (bus.wr_en) begin
                m_data[t]  = bus.in;
                m_valid[t] = 1'b1;
                if (bus.auto_mode) m_ptr = (m_ptr + 1) % 8;
            end
            m_ovw = (m_ovw && !bus.clr_ovw) || hit;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle();
        bus.ctrl = 3'd0; bus.in = 32'd0; bus.wr_en = 1'b0;
        bus.consume = 8'd0; bus.clr_ovw = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #2;
        idle();
    endtask

    task automatic wr_manual(input logic [2:0] c, input logic [31:0] d);
        bus.auto_mode = 1'b0; bus.ctrl = c; bus.in = d; bus.wr_en = 1'b1;
        cycle();
    endtask

    task automatic wr_auto(input logic [31:0] d);
        bus.auto_mode = 1'b1; bus.in = d; bus.wr_en = 1'b1;
        cycle();
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] dut_slot(input int i);
        case (i)
            0: return bus.o0;  1: return bus.o1;  2: return bus.o2;  3: return bus.o3;
            4: return bus.o4;  5: return bus.o5;  6: return bus.o6;  default: return bus.o7;
        endcase
    endfunction

    // Compare process: every negedge, all outputs against the model
    always @(negedge clk) begin
        if (check_en) begin
            for (int i = 0; i < 8; i++) check($sformatf("model_o%0d", i), dut_slot(i), m_data[i]);
            check("model_valid", {24'd0, bus.valid}, {24'd0, m_valid_vec()});
            check("model_count", {28'd0, bus.count}, m_count());
            check("model_full",  {31'd0, bus.full},  {31'd0, m_count() == 8});
            check("model_ptr",   {29'd0, bus.ptr},   m_ptr);
            check("model_ovw",   {31'd0, bus.ovw},   {31'd0, m_ovw});
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        idle();
        bus.auto_mode = 1'b0;
        reset = 1'b1;
        cycle();
        cycle();
        check_en = 1'b1;
        check("rst_valid", {24'd0, bus.valid}, 32'h0);
        check("rst_count", {28'd0, bus.count}, 32'd0);
        reset = 1'b0;

        // Manual writes
        wr_manual(3'd3, 32'hDEADBEEF);
        wr_manual(3'd0, 32'h12345678);
        check("man_o3", bus.o3, 32'hDEADBEEF);
        check("man_o0", bus.o0, 32'h12345678);
        check("man_o1", bus.o1, 32'h0);
        check("man_valid", {24'd0, bus.valid}, 32'h09);
        check("man_count", {28'd0, bus.count}, 32'd2);
        check("man_ovw", {31'd0, bus.ovw}, 32'd0);
        check("man_ptr", {29'd0, bus.ptr}, 32'd0);

        // Auto wrap: words 1..9
        for (int k = 1; k <= 8; k++) wr_auto(k);
        check("auto8_valid", {24'd0, bus.valid}, 32'hFF);
        check("auto8_full", {31'd0, bus.full}, 32'd1);
        check("auto8_count", {28'd0, bus.count}, 32'd8);
        check("auto8_ptr", {29'd0, bus.ptr}, 32'd0);
        wr_auto(32'd9);
        check("auto9_o0", bus.o0, 32'd9);
        check("auto9_o7", bus.o7, 32'd8);
        check("auto9_ovw", {31'd0, bus.ovw}, 32'd1);
        check("auto9_ptr", {29'd0, bus.ptr}, 32'd1);

        // Clear ovw, then simultaneous write + consume on slot 5
        bus.clr_ovw = 1'b1;
        cycle();
        check("clr_ovw", {31'd0, bus.ovw}, 32'd0);
        bus.consume = 8'h20;
        wr_manual(3'd5, 32'hA5A5A5A5);
        check("wc_o5", bus.o5, 32'hA5A5A5A5);
        check("wc_valid5", {31'd0, bus.valid[5]}, 32'd1);
        check("wc_ovw", {31'd0, bus.ovw}, 32'd0);
        check("wc_count", {28'd0, bus.count}, 32'd8);

        // Overwrite slot 6 while full, then consume low half with clr_ovw
        wr_manual(3'd6, 32'h66);
        check("full_wr_ovw", {31'd0, bus.ovw}, 32'd1);
        bus.consume = 8'h0F; bus.clr_ovw = 1'b1;
        cycle();
        check("cons_valid", {24'd0, bus.valid}, 32'hF0);
        check("cons_count", {28'd0, bus.count}, 32'd4);
        check("cons_full", {31'd0, bus.full}, 32'd0);
        check("cons_ovw", {31'd0, bus.ovw}, 32'd0);
        check("cons_o0", bus.o0, 32'd9);
        check("cons_o1", bus.o1, 32'd2);
        check("cons_o2", bus.o2, 32'd3);
        check("cons_o3", bus.o3, 32'd4);

        // Race: clr_ovw with an overwrite of valid slot 4
        bus.clr_ovw = 1'b1;
        wr_manual(3'd4, 32'h44);
        check("race_ovw", {31'd0, bus.ovw}, 32'd1);

        // Build up valid = FF with ptr = 6
        for (int k = 0; k < 5; k++) wr_auto(32'h100 + k);
        wr_manual(3'd0, 32'h200);
        check("pre_rst_valid", {24'd0, bus.valid}, 32'hFF);
        check("pre_rst_ptr", {29'd0, bus.ptr}, 32'd6);

        // Reset mid-operation with a pending auto write
        reset = 1'b1;
        bus.auto_mode = 1'b1; bus.in = 32'hFFFFFFFF; bus.wr_en = 1'b1;
        cycle();
        reset = 1'b0;
        check("mrst_valid", {24'd0, bus.valid}, 32'h0);
        check("mrst_ptr", {29'd0, bus.ptr}, 32'd0);
        check("mrst_o6", bus.o6, 32'h0);
        check("mrst_ovw", {31'd0, bus.ovw}, 32'd0);
        wr_auto(32'h77);
        check("post_rst_o0", bus.o0, 32'h77);
        check("post_rst_ptr", {29'd0, bus.ptr}, 32'd1);
        check("post_rst_count", {28'd0, bus.count}, 32'd1);

        @(negedge clk);
        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
